// File: rtl/store_demux_pkg.sv
// ============================================================================
// Module      : store_demux_pkg
// Description : Shared state encoding, route selects and default widths for
//               the store demultiplexer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package store_demux_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'b00;
    localparam state_t HOLD_A = 2'b01;
    localparam state_t HOLD_B = 2'b10;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEFAULT_CNT_W = 16;

endpackage : store_demux_pkg

`default_nettype wire

// File: rtl/store_demux_xfer_counter.sv
// ============================================================================
// Module      : xfer_counter
// Description : Free-running wrapping transfer counter, one per target port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module xfer_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : xfer_counter

`default_nettype wire

// File: rtl/store_demux.sv
// ============================================================================
// Module      : store_demux
// Description : Registered 1-to-2 store demultiplexer (A = data memory,
//               B = device bus) with valid/ready handshakes and counters.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module store_demux
    import store_demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_addr,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_addr,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_data;
    logic             w_a_hs;
    logic             w_b_hs;
    logic             w_out_hs;
    logic             w_in_hs;

    // Only the selected port's ready can complete a delivery.
    assign w_a_hs   = reset && (r_state == HOLD_A) && a_ready;
    assign w_b_hs   = reset && (r_state == HOLD_B) && b_ready;
    assign w_out_hs = w_a_hs || w_b_hs;

    // Draining the buffer this cycle frees it for a new store: no bubble.
    assign in_ready = reset && ((r_state == IDLE) || w_out_hs);
    assign w_in_hs  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_hs) begin
                    w_next_state = (in_sel == SEL_A) ? HOLD_A : HOLD_B;
                end
            end
            HOLD_A, HOLD_B: begin
                if (w_in_hs) begin
                    w_next_state = (in_sel == SEL_A) ? HOLD_A : HOLD_B;
                end else if (w_out_hs) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (w_in_hs) begin
            r_addr <= in_addr;
            r_data <= in_data;
        end
    end

    always_comb begin
        a_valid = 1'b0;
        a_addr  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_addr  = '0;
        b_data  = '0;
        case (r_state)
            HOLD_A: begin
                a_valid = 1'b1;
                a_addr  = r_addr;
                a_data  = r_data;
            end
            HOLD_B: begin
                b_valid = 1'b1;
                b_addr  = r_addr;
                b_data  = r_data;
            end
            default: ;
        endcase
    end

    xfer_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_a (
        .clk   (clk),
        .reset (reset),
        .inc   (w_a_hs),
        .count (a_count)
    );

    xfer_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_b (
        .clk   (clk),
        .reset (reset),
        .inc   (w_b_hs),
        .count (b_count)
    );

endmodule : store_demux

`default_nettype wire

// File: tb/tb_store_demux.sv
// ============================================================================
// Module      : tb_store_demux
// Description : Scoreboard bench for store_demux: directed stores are queued
//               as expected deliveries and a monitor checks each delivery.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_store_demux;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_addr;
    logic [WIDTH-1:0] in_data;
    logic             a_valid, a_ready, b_valid, b_ready;
    logic [WIDTH-1:0] a_addr, a_data, b_addr, b_data;
    logic [CNT_W-1:0] a_count, b_count;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    store_demux #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a store and wait (bounded) for the edge that accepts it.
    task automatic send(input logic sel, input logic [31:0] addr, input logic [31:0] data,
                        input bit must_be_ready_now);
        bit   got;
        exp_t e;
        in_valid = 1'b1;
        in_sel   = sel;
        in_addr  = addr;
        in_data  = data;
        got      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0 && must_be_ready_now) chk("in_ready_no_bubble", {31'd0, in_ready}, 32'd1);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for addr 0x%08h", addr);
        end else begin
            e.sel  = sel;
            e.addr = addr;
            e.data = data;
            sb.push_back(e);
        end
        step();
    endtask

    // Monitor: every completed delivery must match the oldest queued store.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && ((a_valid && a_ready) || (b_valid && b_ready))) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: a_valid=%0b b_valid=%0b expected none", a_valid, b_valid);
                end else begin
                    e = sb.pop_front();
                    chk("deliv_port", {31'd0, b_valid}, {31'd0, e.sel});
                    chk("deliv_addr", b_valid ? b_addr : a_addr, e.addr);
                    chk("deliv_data", b_valid ? b_data : a_data, e.data);
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        step();
        step();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_valids", {30'd0, a_valid, b_valid}, 32'd0);
        chk("rst_a_data", a_data, 32'd0);
        chk("rst_b_addr", b_addr, 32'd0);
        chk("rst_counts", {a_count, b_count}, 32'd0);
        step();
        reset = 1'b1;

        // Single store to A
        a_ready = 1'b1;
        send(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_a_valid", {31'd0, a_valid}, 32'd1);
        chk("single_a_addr", a_addr, 32'h0000_1000);
        chk("single_b_valid", {31'd0, b_valid}, 32'd0);
        chk("single_b_data", b_data, 32'd0);
        step();
        @(negedge clk);
        chk("single_a_gone", {31'd0, a_valid}, 32'd0);
        chk("single_a_count", {16'd0, a_count}, 32'd1);
        step();

        // Backpressure on B
        b_ready = 1'b0;
        send(1'b1, 32'h0000_2000, 32'h1234_5678, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_b_valid", {31'd0, b_valid}, 32'd1);
            chk("stall_b_data", b_data, 32'h1234_5678);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        chk("stall_b_count", {16'd0, b_count}, 32'd0);
        b_ready = 1'b1;
        step();
        @(negedge clk);
        chk("stall_b_count_after", {16'd0, b_count}, 32'd1);
        chk("stall_b_gone", {31'd0, b_valid}, 32'd0);
        step();

        // Back-to-back alternating A, B, A, B
        send(1'b0, 32'h0000_3000, 32'hA000_0001, 1'b1);
        send(1'b1, 32'h0000_3004, 32'hB000_0002, 1'b1);
        send(1'b0, 32'h0000_3008, 32'hA000_0003, 1'b1);
        send(1'b1, 32'h0000_300C, 32'hB000_0004, 1'b1);
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("b2b_a_count", {16'd0, a_count}, 32'd3);
        chk("b2b_b_count", {16'd0, b_count}, 32'd3);
        chk("b2b_drained", sb.size(), 32'd0);
        step();

        // Ready on the wrong port is ignored
        a_ready = 1'b0;
        b_ready = 1'b1;
        send(1'b0, 32'h0000_4000, 32'hCAFE_F00D, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wrong_a_valid", {31'd0, a_valid}, 32'd1);
            chk("wrong_b_valid", {31'd0, b_valid}, 32'd0);
            chk("wrong_counts", {a_count, b_count}, {16'd3, 16'd3});
            step();
        end
        a_ready = 1'b1;
        step();
        @(negedge clk);
        chk("wrong_release_a_count", {16'd0, a_count}, 32'd4);
        step();

        // Reset while a store to B is pending
        b_ready = 1'b0;
        send(1'b1, 32'h0000_5000, 32'h55AA_55AA, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_b_valid", {31'd0, b_valid}, 32'd1);
        step();
        reset   = 1'b0;
        b_ready = 1'b1;
        chk("rstmid_pending", sb.size(), 32'd1);
        sb.delete();
        @(negedge clk);
        chk("rstmid_in_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_b_valid_after", {31'd0, b_valid}, 32'd0);
        chk("rstmid_b_data_after", b_data, 32'd0);
        chk("rstmid_counts", {a_count, b_count}, 32'd0);
        chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // Counter wrap on A after 65536 deliveries
        a_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            send(1'b0, i, ~i, (i != 0));
        end
        @(negedge clk);
        chk("wrap_a_count_max", {16'd0, a_count}, 32'h0000_FFFF);
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("wrap_a_count", {16'd0, a_count}, 32'd0);
        chk("wrap_b_count", {16'd0, b_count}, 32'd0);
        chk("wrap_a_valid", {31'd0, a_valid}, 32'd0);
        chk("final_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_store_demux

`default_nettype wire
